lcd_hd44780_receiver: RTL

Device-side model of the HD44780 4-bit write interface that our LCD controller drives. It decodes the interface and mirrors the 2x16 display state. It synchronizes the lcd_* pins, assembles nibbles into bytes, and executes the command/data subset the controller uses. It holds a 32-byte DDRAM image, cursor and mode flags, and emulates the busy period. Its uses are closed-loop bring-up, on-board display mirroring, and self-checking benches of the controller.

---
 rtl/lcd_hd44780_pkg.sv | 43 ++++
 rtl/lcd_nibble_assembler.sv | 90 +++++++++
 rtl/lcd_hd44780_receiver.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_hd44780_pkg.sv
// Shared constants, state encoding and AC stepping rule for the HD44780 receiver model.
package lcd_hd44780_pkg;

  // Command classes are recognised by their highest set bit.
  localparam logic [7:0] CMD_CLEAR  = 8'h01;
  localparam logic [7:0] MASK_HOME  = 8'h02;
  localparam logic [7:0] MASK_ENTRY = 8'h04;
  localparam logic [7:0] MASK_DISP  = 8'h08;
  localparam logic [7:0] MASK_SHIFT = 8'h10;
  localparam logic [7:0] MASK_FUNC  = 8'h20;
  localparam logic [7:0] MASK_CGRAM = 8'h40;
  localparam logic [7:0] MASK_DDRAM = 8'h80;

  localparam logic [6:0] LINE1_BASE = 7'h00;
  localparam logic [6:0] LINE2_BASE = 7'h40;
  localparam logic [6:0] LINE1_END  = 7'h27;
  localparam logic [6:0] LINE2_END  = 7'h67;

  localparam logic [7:0] FILL_BYTE  = 8'h20;
  localparam int         IMG_DEPTH  = 32;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    CLEAR_FILL,
    BUSY_WAIT
  } rx_state_t;

  function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
    logic [6:0] nxt;
    if (inc) begin
      if (ac == LINE1_END)      nxt = LINE2_BASE;
      else if (ac == LINE2_END) nxt = LINE1_BASE;
      else                      nxt = ac + 7'd1;
    end else begin
      if (ac == LINE1_BASE)      nxt = LINE2_END;
      else if (ac == LINE2_BASE) nxt = LINE1_END;
      else                       nxt = ac - 7'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/lcd_nibble_assembler.sv
// Synchronizes the LCD pins, detects EN falling edges and assembles 4/8-bit writes into bytes.
module lcd_nibble_assembler
  import lcd_hd44780_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_lcd_rs,
  input  logic       i_lcd_rw,
  input  logic       i_lcd_en,
  input  logic [3:0] i_lcd_data,
  input  logic       i_four_bit,
  output logic       o_byte_vld,
  output logic [7:0] o_byte,
  output logic       o_rs,
  output logic       o_err
);

  // Pin bundle layout: [6]=rs [5]=rw [4]=en [3:0]=data
  logic [6:0] r_pin_p0;
  logic [6:0] r_pin_p1;
  logic [6:0] r_pin_p2;
  logic       r_phase;
  logic [3:0] r_hi_nib;
  logic       r_hi_rs;

  logic       w_strobe;
  logic       w_rs;
  logic       w_rw;
  logic [3:0] w_nib;
  logic       w_phase_nxt;
  logic       w_hi_load;

  // p0/p1 are the synchronizer; p2 holds the values seen while EN was still high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pin_p0 <= '0;
      r_pin_p1 <= '0;
      r_pin_p2 <= '0;
    end else begin
      r_pin_p0 <= {i_lcd_rs, i_lcd_rw, i_lcd_en, i_lcd_data};
      r_pin_p1 <= r_pin_p0;
      r_pin_p2 <= r_pin_p1;
    end
  end

  assign w_strobe = r_pin_p2[4] & ~r_pin_p1[4];
  assign w_rs     = r_pin_p2[6];
  assign w_rw     = r_pin_p2[5];
  assign w_nib    = r_pin_p2[3:0];

  always_comb begin
    o_byte_vld  = 1'b0;
    o_byte      = {w_nib, 4'h0};
    o_rs        = w_rs;
    o_err       = 1'b0;
    w_hi_load   = 1'b0;
    w_phase_nxt = r_phase & i_four_bit;
    if (w_strobe) begin
      if (w_rw) begin
        o_err = 1'b1;
      end else if (!i_four_bit) begin
        o_byte_vld  = 1'b1;
        w_phase_nxt = 1'b0;
      end else if (!r_phase) begin
        w_hi_load   = 1'b1;
        w_phase_nxt = 1'b1;
      end else begin
        o_byte_vld  = 1'b1;
        o_byte      = {r_hi_nib, w_nib};
        o_err       = (r_hi_rs != w_rs);
        w_phase_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase  <= 1'b0;
      r_hi_nib <= '0;
      r_hi_rs  <= 1'b0;
    end else begin
      r_phase <= w_phase_nxt;
      if (w_hi_load) begin
        r_hi_nib <= w_nib;
        r_hi_rs  <= w_rs;
      end
    end
  end

endmodule

// File: rtl/lcd_hd44780_receiver.sv
// HD44780 4-bit write-side model: executes the command subset, mirrors the 2x16 DDRAM and emulates busy.
module lcd_hd44780_receiver
  import lcd_hd44780_pkg::*;
#(
  parameter int BUSY_CYCLES  = 37,
  parameter int CLEAR_CYCLES = 1520
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic       lcd_en,
  input  logic [3:0] lcd_data,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       evt_valid,
  output logic       evt_rs,
  output logic [7:0] evt_byte,
  output logic       evt_dropped,
  output logic [6:0] cursor_addr,
  output logic       display_on,
  output logic       four_bit,
  output logic       two_line,
  output logic       inc_mode,
  output logic       busy,
  output logic       protocol_err
);

  localparam int CNT_W = $clog2((CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES) + 1;

  logic             w_byte_vld;
  logic [7:0]       w_byte;
  logic             w_byte_rs;
  logic             w_asm_err;

  rx_state_t        r_state;
  rx_state_t        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [4:0]       r_fill_idx;
  logic [4:0]       w_fill_nxt;
  logic             w_fill_we;

  logic [6:0]       r_ac;
  logic             r_disp;
  logic             r_four;
  logic             r_two;
  logic             r_inc;
  logic             r_cg_mode;
  logic [6:0]       w_ac_nxt;
  logic             w_disp_nxt;
  logic             w_four_nxt;
  logic             w_two_nxt;
  logic             w_inc_nxt;
  logic             w_cg_nxt;
  logic             w_wr_en;
  logic             w_long;
  logic             w_clear;
  logic [4:0]       w_wr_idx;

  logic             w_busy;
  logic             w_exec;
  logic             w_drop;

  logic [7:0]       r_image [IMG_DEPTH];
  logic [7:0]       r_rd_data;
  logic             r_evt_valid;
  logic             r_evt_rs;
  logic [7:0]       r_evt_byte;
  logic             r_evt_dropped;
  logic             r_err;

  lcd_nibble_assembler u_asm (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_lcd_rs   (lcd_rs),
    .i_lcd_rw   (lcd_rw),
    .i_lcd_en   (lcd_en),
    .i_lcd_data (lcd_data),
    .i_four_bit (r_four),
    .o_byte_vld (w_byte_vld),
    .o_byte     (w_byte),
    .o_rs       (w_byte_rs),
    .o_err      (w_asm_err)
  );

  assign w_busy   = (r_state != IDLE);
  assign w_exec   = w_byte_vld & ~w_busy;
  assign w_drop   = w_byte_vld & w_busy;
  // Line 1 occupies 0x00-0x0F, line 2 0x40-0x4F; bit 6 selects the upper half of the image
  assign w_wr_idx = {r_ac[6], r_ac[3:0]};

  always_comb begin
    w_ac_nxt   = r_ac;
    w_disp_nxt = r_disp;
    w_four_nxt = r_four;
    w_two_nxt  = r_two;
    w_inc_nxt  = r_inc;
    w_cg_nxt   = r_cg_mode;
    w_wr_en    = 1'b0;
    w_long     = 1'b0;
    w_clear    = 1'b0;
    if (w_exec) begin
      if (w_byte_rs) begin
        w_wr_en  = ~r_cg_mode & (r_ac[5:4] == 2'b00);
        w_ac_nxt = ac_step(r_ac, r_inc);
      end else if (|(w_byte & MASK_DDRAM)) begin
        w_ac_nxt = w_byte[6:0];
        w_cg_nxt = 1'b0;
      end else if (|(w_byte & MASK_CGRAM)) begin
        w_cg_nxt = 1'b1;
      end else if (|(w_byte & MASK_FUNC)) begin
        w_four_nxt = ~w_byte[4];
        w_two_nxt  = w_byte[3];
      end else if (|(w_byte & MASK_SHIFT)) begin
        if (!w_byte[3]) w_ac_nxt = ac_step(r_ac, w_byte[2]);
      end else if (|(w_byte & MASK_DISP)) begin
        w_disp_nxt = w_byte[2];
      end else if (|(w_byte & MASK_ENTRY)) begin
        w_inc_nxt = w_byte[1];
      end else if (|(w_byte & MASK_HOME)) begin
        w_ac_nxt = LINE1_BASE;
        w_cg_nxt = 1'b0;
        w_long   = 1'b1;
      end else if (w_byte == CMD_CLEAR) begin
        w_ac_nxt  = LINE1_BASE;
        w_cg_nxt  = 1'b0;
        w_inc_nxt = 1'b1;
        w_long    = 1'b1;
        w_clear   = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_fill_nxt  = r_fill_idx;
    w_fill_we   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_exec) begin
          w_cnt_nxt   = w_long ? CNT_W'(CLEAR_CYCLES - 1) : CNT_W'(BUSY_CYCLES - 1);
          w_state_nxt = w_clear ? CLEAR_FILL : EXEC;
          w_fill_nxt  = '0;
        end
      end
      EXEC, BUSY_WAIT: begin
        if (r_cnt == '0) begin
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt   = r_cnt - CNT_W'(1);
          w_state_nxt = BUSY_WAIT;
        end
      end
      CLEAR_FILL: begin
        w_fill_we  = 1'b1;
        w_fill_nxt = r_fill_idx + 5'd1;
        if (r_cnt != '0) w_cnt_nxt = r_cnt - CNT_W'(1);
        if (r_fill_idx == 5'd31) w_state_nxt = (r_cnt == '0) ? IDLE : BUSY_WAIT;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_fill_idx    <= '0;
      r_ac          <= '0;
      r_disp        <= 1'b0;
      r_four        <= 1'b0;
      r_two         <= 1'b0;
      r_inc         <= 1'b1;
      r_cg_mode     <= 1'b0;
      r_evt_valid   <= 1'b0;
      r_evt_rs      <= 1'b0;
      r_evt_byte    <= '0;
      r_evt_dropped <= 1'b0;
      r_err         <= 1'b0;
      r_rd_data     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_fill_idx  <= w_fill_nxt;
      r_ac        <= w_ac_nxt;
      r_disp      <= w_disp_nxt;
      r_four      <= w_four_nxt;
      r_two       <= w_two_nxt;
      r_inc       <= w_inc_nxt;
      r_cg_mode   <= w_cg_nxt;
      r_evt_valid <= w_byte_vld;
      if (w_byte_vld) begin
        r_evt_rs      <= w_byte_rs;
        r_evt_byte    <= w_byte;
        r_evt_dropped <= w_busy;
      end
      r_err     <= r_err | w_asm_err | w_drop;
      r_rd_data <= r_image[rd_addr];
    end
  end

  // The image resets to blanks too, so a reset mid-fill leaves no partial clear behind
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < IMG_DEPTH; i++) r_image[i] <= FILL_BYTE;
    end else if (w_fill_we) begin
      r_image[r_fill_idx] <= FILL_BYTE;
    end else if (w_wr_en) begin
      r_image[w_wr_idx] <= w_byte;
    end
  end

  assign rd_data      = r_rd_data;
  assign evt_valid    = r_evt_valid;
  assign evt_rs       = r_evt_rs;
  assign evt_byte     = r_evt_byte;
  assign evt_dropped  = r_evt_dropped;
  assign cursor_addr  = r_ac;
  assign display_on   = r_disp;
  assign four_bit     = r_four;
  assign two_line     = r_two;
  assign inc_mode     = r_inc;
  assign busy         = w_busy;
  assign protocol_err = r_err;

endmodule
